// File: rtl/src_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : src_scan_ctrl_pkg
// Purpose  : Shared constants and state type for the source-buffer scan
//            sequencer (image/kernel geometry, read-address width, FSM states).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package src_scan_ctrl_pkg;

  // Image and kernel geometry (stride 1, no padding)
  localparam int SRC_IMG_W = 28;
  localparam int SRC_IMG_H = 28;
  localparam int SRC_K     = 5;
  localparam int SRC_OUT_W = SRC_IMG_W - SRC_K + 1;
  localparam int SRC_OUT_H = SRC_IMG_H - SRC_K + 1;

  // Source buffer read-address width
  localparam int SRC_AW    = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DRAIN = 2'd3
  } scan_state_e;

endpackage : src_scan_ctrl_pkg
`default_nettype wire

// File: rtl/src_scan_ctrl_win_tap_counter.sv
`default_nettype none
// ============================================================================
// Module   : win_tap_counter
// Purpose  : Nested raster counters kc (innermost), kr, oc, orow that walk
//            every tap of every KxK window and form the buffer read address.
// Ports    : clk, rst     - clock, synchronous active-high reset
//            clr_i        - clear all counters (start of a new frame)
//            adv_i        - advance to the next tap
//            addr_o       - (orow+kr)*IMG_W + oc + kc, truncated to AW bits
//            first_o      - current tap is kr=0,kc=0
//            last_o       - current tap is kr=K-1,kc=K-1
//            frame_end_o  - current tap is the last tap of the last window
// Revision : 1.0 - initial release
// ============================================================================
module win_tap_counter
  import src_scan_ctrl_pkg::*;
#(
  parameter int IMG_W = SRC_IMG_W,
  parameter int IMG_H = SRC_IMG_H,
  parameter int K     = SRC_K,
  parameter int AW    = SRC_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [AW-1:0] addr_o,
  output logic          first_o,
  output logic          last_o,
  output logic          frame_end_o
);

  localparam int OW = IMG_W - K + 1;
  localparam int OH = IMG_H - K + 1;
  localparam int CW = $clog2(((IMG_W > IMG_H) ? IMG_W : IMG_H) + 1);

  localparam logic [CW-1:0] KMAX  = CW'(K - 1);
  localparam logic [CW-1:0] OCMAX = CW'(OW - 1);
  localparam logic [CW-1:0] ORMAX = CW'(OH - 1);

  logic [CW-1:0] kc_q, kr_q, oc_q, orow_q;

  // Odometer-style carry chain; the final tap wraps everything back to zero.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      kc_q   <= '0;
      kr_q   <= '0;
      oc_q   <= '0;
      orow_q <= '0;
    end else if (adv_i) begin
      if (kc_q != KMAX) begin
        kc_q <= kc_q + 1'b1;
      end else begin
        kc_q <= '0;
        if (kr_q != KMAX) begin
          kr_q <= kr_q + 1'b1;
        end else begin
          kr_q <= '0;
          if (oc_q != OCMAX) begin
            oc_q <= oc_q + 1'b1;
          end else begin
            oc_q <= '0;
            if (orow_q != ORMAX) orow_q <= orow_q + 1'b1;
            else                 orow_q <= '0;
          end
        end
      end
    end
  end

  // Arithmetic is done modulo 2^AW, which is the required truncation.
  assign addr_o = (AW'(orow_q) + AW'(kr_q)) * AW'(IMG_W) + AW'(oc_q) + AW'(kc_q);

  assign first_o     = (kc_q == '0) && (kr_q == '0);
  assign last_o      = (kc_q == KMAX) && (kr_q == KMAX);
  assign frame_end_o = last_o && (oc_q == OCMAX) && (orow_q == ORMAX);

endmodule : win_tap_counter
`default_nettype wire

// File: rtl/src_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : src_scan_ctrl
// Purpose  : Loads a frame into the source buffer, then scans every KxK
//            window in raster order, issuing one read per tap and presenting
//            the returned pixel with a valid/ready handshake and markers.
// Ports    : clk, rstn    - clock, synchronous reset (active HIGH)
//            start        - frame request (accepted only when idle)
//            busy, done   - frame in progress / one-cycle completion pulse
//            load_go      - pulse to buffer load; load_ready - load complete
//            rom_cena     - active-low read enable; rom_aa - read address
//            tap_valid/tap_ready - tap handshake with the conv stage
//            tap_first, tap_last, frame_last - window/frame markers
// Revision : 1.0 - initial release
// ============================================================================
module src_scan_ctrl
  import src_scan_ctrl_pkg::*;
#(
  parameter int IMG_W = SRC_IMG_W,
  parameter int IMG_H = SRC_IMG_H,
  parameter int K     = SRC_K,
  parameter int AW    = SRC_AW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          load_go,
  input  logic          load_ready,
  output logic          rom_cena,
  output logic [AW-1:0] rom_aa,
  output logic          tap_valid,
  input  logic          tap_ready,
  output logic          tap_first,
  output logic          tap_last,
  output logic          frame_last
);

  scan_state_e state_q, state_d;
  logic        tap_valid_q, tap_valid_d;
  logic        first_q, first_d;
  logic        last_q, last_d;
  logic        flast_q, flast_d;
  logic        done_q, done_d;

  logic          w_issue;
  logic          w_clr;
  logic          w_go;
  logic [AW-1:0] w_addr;
  logic          w_first, w_last, w_frame_end;

  win_tap_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .K     (K),
    .AW    (AW)
  ) u_cnt (
    .clk         (clk),
    .rst         (rstn),
    .clr_i       (w_clr),
    .adv_i       (w_issue),
    .addr_o      (w_addr),
    .first_o     (w_first),
    .last_o      (w_last),
    .frame_end_o (w_frame_end)
  );

  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    w_issue     = 1'b0;
    w_clr       = 1'b0;
    w_go        = 1'b0;
    tap_valid_d = tap_valid_q;
    first_d     = first_q;
    last_d      = last_q;
    flast_d     = flast_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          w_go    = 1'b1;
          w_clr   = 1'b1;
        end
      end
      ST_LOAD: begin
        if (load_ready) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        // A read may only be issued when the output slot frees up this cycle;
        // otherwise the buffer must hold the data of the stalled tap.
        if (!tap_valid_q || tap_ready) begin
          w_issue = 1'b1;
          if (w_frame_end) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (tap_valid_q && tap_ready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Markers travel with the read so they line up with the returned pixel.
    if (w_issue) begin
      tap_valid_d = 1'b1;
      first_d     = w_first;
      last_d      = w_last;
      flast_d     = w_frame_end;
    end else if (tap_ready) begin
      tap_valid_d = 1'b0;
      first_d     = 1'b0;
      last_d      = 1'b0;
      flast_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q     <= ST_IDLE;
      tap_valid_q <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      flast_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_valid_q <= tap_valid_d;
      first_q     <= first_d;
      last_q      <= last_d;
      flast_q     <= flast_d;
      done_q      <= done_d;
    end
  end

  // Combinational strobes are masked while reset is held so no stray read
  // or load request escapes during the reset cycle.
  assign load_go    = w_go && !rstn;
  assign rom_cena   = !(w_issue && !rstn);
  assign rom_aa     = w_addr;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign tap_valid  = tap_valid_q;
  assign tap_first  = first_q;
  assign tap_last   = last_q;
  assign frame_last = flast_q;

endmodule : src_scan_ctrl
`default_nettype wire

// File: tb/tb_src_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_src_scan_ctrl
// Purpose  : Self-checking bench for src_scan_ctrl with a behavioural model of
//            the source buffer and a nested-loop reference of the tap order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_src_scan_ctrl;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int K     = 5;
  localparam int AW    = 12;
  localparam int OW    = IMG_W - K + 1;
  localparam int OH    = IMG_H - K + 1;
  localparam int KK    = K * K;
  localparam int TAPS  = OW * OH * KK;

  localparam int M_RANDOM = 1;
  localparam int M_STALL  = 2;
  localparam int M_INJECT = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic          load_ready;
  logic          tap_ready;
  logic          busy, done, load_go, rom_cena;
  logic [AW-1:0] rom_aa;
  logic          tap_valid, tap_first, tap_last, frame_last;

  logic [15:0]   mem [0:4095];
  logic [15:0]   rdata;
  int            exp_addr [TAPS];
  int            got_addr [TAPS];
  int            n_checks = 0;
  int            n_errors = 0;

  src_scan_ctrl #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .K     (K),
    .AW    (AW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .load_go    (load_go),
    .load_ready (load_ready),
    .rom_cena   (rom_cena),
    .rom_aa     (rom_aa),
    .tap_valid  (tap_valid),
    .tap_ready  (tap_ready),
    .tap_first  (tap_first),
    .tap_last   (tap_last),
    .frame_last (frame_last)
  );

  always #5 clk = ~clk;

  // Source buffer: 1-cycle registered read, data held while not enabled.
  always @(posedge clk) begin
    if (rom_cena === 1'b0) rdata <= mem[rom_aa];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic build_model();
    int n;
    n = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    for (int r = 0; r < OH; r++)
      for (int c = 0; c < OW; c++)
        for (int kr = 0; kr < K; kr++)
          for (int kc = 0; kc < K; kc++) begin
            exp_addr[n] = (r + kr) * IMG_W + c + kc;
            n++;
          end
  endtask

  // Runs one frame: start, load handshake, then the scan with the requested
  // ready pattern. Stops early at abort_at accepted taps when abort_at > 0.
  task automatic scan_frame(input int mode, input int load_delay, input int abort_at,
                            output int n_acc, output int n_cyc);
    int          n_iss;
    int          cyc;
    int          stall_cnt;
    bit          stall_checked;
    bit          finished;
    logic        prev_valid, prev_ready, prev_issue;
    logic [15:0] prev_data;
    logic [2:0]  prev_mk;
    logic        exp_v;
    n_iss = 0; cyc = 0; stall_cnt = 0; stall_checked = 0; finished = 0;
    prev_valid = 0; prev_ready = 0; prev_issue = 0; prev_data = '0; prev_mk = '0;
    n_acc = 0;

    @(negedge clk); start = 1'b1; #1;
    n_checks++;
    if (load_go !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL start_cycle: load_go=%b busy=%b, want 1/0", load_go, busy);
    end
    @(negedge clk); start = 1'b0; #1;
    n_checks++;
    if (load_go !== 1'b0 || busy !== 1'b1 || rom_cena !== 1'b1) begin
      n_errors++;
      $display("FAIL load_enter: load_go=%b busy=%b rom_cena=%b, want 0/1/1", load_go, busy, rom_cena);
    end
    for (int i = 1; i < load_delay; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if (rom_cena !== 1'b1 || load_go !== 1'b0 || busy !== 1'b1) begin
        n_errors++;
        $display("FAIL load_wait: rom_cena=%b load_go=%b busy=%b, want 1/0/1", rom_cena, load_go, busy);
      end
    end
    @(negedge clk); load_ready = 1'b1; #1;
    n_checks++;
    if (rom_cena !== 1'b1) begin
      n_errors++;
      $display("FAIL load_ready_cycle: rom_cena=%b, want 1", rom_cena);
    end

    while (!finished) begin
      @(negedge clk);
      load_ready = 1'b0;
      start      = 1'b0;
      if (abort_at > 0 && n_acc >= abort_at) break;
      if (cyc > 40000 || n_errors > 40) begin
        n_checks++; n_errors++;
        $display("FAIL scan_budget: accepted=%0d of %0d after %0d cycles", n_acc, TAPS, cyc);
        break;
      end
      if (((mode & M_STALL) != 0) && n_acc == 0 && stall_cnt < 50) tap_ready = 1'b0;
      else if ((mode & M_RANDOM) != 0) tap_ready = ($urandom_range(0, 9) >= 3);
      else tap_ready = 1'b1;
      if ((mode & M_INJECT) != 0) begin
        if (cyc == 300) start = 1'b1;
        if (cyc == 600) load_ready = 1'b1;
      end
      #1;

      exp_v = prev_issue || (prev_valid && !prev_ready);
      n_checks++;
      if (tap_valid !== exp_v) begin
        n_errors++;
        $display("FAIL tap_valid cyc=%0d: got %b, want %b", cyc, tap_valid, exp_v);
      end
      if (cyc == 0) begin
        n_checks++;
        if (rom_cena !== 1'b0 || rom_aa !== AW'(0)) begin
          n_errors++;
          $display("FAIL scan_entry: rom_cena=%b rom_aa=%0d, want 0/0", rom_cena, rom_aa);
        end
      end
      if (prev_valid && !prev_ready) begin
        n_checks++;
        if (rdata !== prev_data || {tap_first, tap_last, frame_last} !== prev_mk) begin
          n_errors++;
          $display("FAIL stall_hold cyc=%0d: data=%h mk=%b, want data=%h mk=%b",
                   cyc, rdata, {tap_first, tap_last, frame_last}, prev_data, prev_mk);
        end
      end
      if (tap_valid && !tap_ready) begin
        n_checks++;
        if (rom_cena !== 1'b1) begin
          n_errors++;
          $display("FAIL stall_no_read cyc=%0d: rom_cena=%b, want 1", cyc, rom_cena);
        end
      end
      if (start) begin
        n_checks++;
        if (load_go !== 1'b0) begin
          n_errors++;
          $display("FAIL start_ignored: load_go=%b, want 0", load_go);
        end
      end
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
        n_errors++;
        $display("FAIL in_frame cyc=%0d: done=%b busy=%b, want 0/1", cyc, done, busy);
      end

      if (tap_valid && tap_ready) begin
        n_checks++;
        if (rdata !== mem[exp_addr[n_acc]] ||
            tap_first !== (n_acc % KK == 0) ||
            tap_last !== (n_acc % KK == KK - 1) ||
            frame_last !== (n_acc == TAPS - 1)) begin
          n_errors++;
          $display("FAIL tap#%0d: data=%h f/l/fl=%b%b%b, want data=%h f/l/fl=%b%b%b",
                   n_acc, rdata, tap_first, tap_last, frame_last, mem[exp_addr[n_acc]],
                   (n_acc % KK == 0), (n_acc % KK == KK - 1), (n_acc == TAPS - 1));
        end
        n_acc++;
        if (n_acc == TAPS) finished = 1;
      end

      if (rom_cena === 1'b0) begin
        n_checks++;
        if (n_iss >= TAPS) begin
          n_errors++;
          $display("FAIL extra_issue: read #%0d addr=%0d, want none", n_iss, rom_aa);
        end else begin
          got_addr[n_iss] = int'(rom_aa);
          if (int'(rom_aa) != exp_addr[n_iss]) begin
            n_errors++;
            $display("FAIL addr#%0d: got %0d, want %0d", n_iss, rom_aa, exp_addr[n_iss]);
          end
        end
        n_iss++;
      end

      if (tap_valid && !tap_ready && n_acc == 0) stall_cnt++;
      if (((mode & M_STALL) != 0) && stall_cnt == 50 && !stall_checked) begin
        stall_checked = 1;
        n_checks++;
        if (n_iss != 1) begin
          n_errors++;
          $display("FAIL stall_one_read: reads=%0d, want 1", n_iss);
        end
      end

      prev_issue = (rom_cena === 1'b0);
      prev_valid = tap_valid;
      prev_ready = tap_ready;
      prev_data  = rdata;
      prev_mk    = {tap_first, tap_last, frame_last};
      cyc++;
    end
    n_cyc = cyc;

    if (abort_at == 0) begin
      @(negedge clk); #1;
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || tap_valid !== 1'b0 || rom_cena !== 1'b1) begin
        n_errors++;
        $display("FAIL done_pulse: done=%b busy=%b valid=%b cena=%b, want 1/0/0/1",
                 done, busy, tap_valid, rom_cena);
      end
      @(negedge clk); #1;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_errors++;
        $display("FAIL done_once: done=%b busy=%b, want 0/0", done, busy);
      end
      n_checks++;
      if (n_iss != TAPS) begin
        n_errors++;
        $display("FAIL read_count: got %0d, want %0d", n_iss, TAPS);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || load_go !== 1'b0 || rom_cena !== 1'b1 ||
        rom_aa !== AW'(0) || tap_valid !== 1'b0 || tap_first !== 1'b0 ||
        tap_last !== 1'b0 || frame_last !== 1'b0) begin
      n_errors++;
      $display("FAIL %s: busy=%b done=%b go=%b cena=%b aa=%0d v=%b f=%b l=%b fl=%b, want 0 0 0 1 0 0 0 0 0",
               tag, busy, done, load_go, rom_cena, rom_aa, tap_valid, tap_first, tap_last, frame_last);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b1; start = 1'b0; load_ready = 1'b0; tap_ready = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b0; #1;
    check_reset_values("reset_values");
    @(negedge clk); load_ready = 1'b1; #1;
    n_checks++;
    if (rom_cena !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_load_ready: cena=%b busy=%b, want 1/0", rom_cena, busy);
    end
    @(negedge clk); load_ready = 1'b0; #1;
    n_checks++;
    if (rom_cena !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_ignore: cena=%b busy=%b, want 1/0", rom_cena, busy);
    end
  endtask

  task automatic test_stream();
    int n, c;
    int first10 [10];
    first10 = '{0, 1, 2, 3, 4, 28, 29, 30, 31, 32};
    scan_frame(0, 790, 0, n, c);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (got_addr[i] != first10[i]) begin
        n_errors++;
        $display("FAIL first_addr[%0d]: got %0d, want %0d", i, got_addr[i], first10[i]);
      end
    end
    n_checks++;
    if (got_addr[KK - 1] != 116 || got_addr[KK] != 1 || got_addr[TAPS - 1] != 783) begin
      n_errors++;
      $display("FAIL window_bounds: tap24=%0d tap25=%0d last=%0d, want 116/1/783",
               got_addr[KK - 1], got_addr[KK], got_addr[TAPS - 1]);
    end
    n_checks++;
    if (n != TAPS || c != TAPS + 1) begin
      n_errors++;
      $display("FAIL throughput: taps=%0d cycles=%0d, want %0d/%0d", n, c, TAPS, TAPS + 1);
    end
  endtask

  task automatic test_random_backpressure();
    int n, c;
    scan_frame(M_RANDOM, 20, 0, n, c);
    n_checks++;
    if (n != TAPS) begin
      n_errors++;
      $display("FAIL random_taps: got %0d, want %0d", n, TAPS);
    end
  endtask

  task automatic test_stall_and_ignore();
    int n, c;
    scan_frame(M_STALL | M_INJECT, 20, 0, n, c);
    n_checks++;
    if (n != TAPS) begin
      n_errors++;
      $display("FAIL stall_taps: got %0d, want %0d", n, TAPS);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n, c;
    scan_frame(0, 20, 5000, n, c);
    rstn = 1'b1;
    @(negedge clk); #1;
    check_reset_values("midframe_reset");
    rstn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || rom_cena !== 1'b1 || tap_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL post_reset_quiet: done=%b busy=%b cena=%b v=%b, want 0/0/1/0",
                 done, busy, rom_cena, tap_valid);
      end
    end
    scan_frame(0, 20, 0, n, c);
    n_checks++;
    if (n != TAPS || got_addr[0] != 0) begin
      n_errors++;
      $display("FAIL restart_frame: taps=%0d first_addr=%0d, want %0d/0", n, got_addr[0], TAPS);
    end
  endtask

  initial begin
    rstn = 1'b1; start = 1'b0; load_ready = 1'b0; tap_ready = 1'b0;
    build_model();
    test_reset();
    test_stream();
    test_random_backpressure();
    test_stall_and_ignore();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_src_scan_ctrl
`default_nettype wire

// File: doc/src_scan_ctrl.md
Name: src_scan_ctrl

Overview:
- Sequencer for the input-image source buffer (28x28 pixels, 784 words, 12-bit read address, 1-cycle registered read, active-low read enable).
- Starts a frame load by pulsing the buffer's load-go input, then waits for its load-ready pulse.
- Then scans every KxK convolution window in raster order and issues one read address per tap.
- Presents each returned pixel to the first conv stage with a valid/ready handshake and window/frame markers.

Parameters:
- IMG_W, 28, image width in pixels
- IMG_H, 28, image height in pixels
- K, 5, square kernel size (stride fixed at 1, no padding)
- AW, 12, read-address width

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous reset, active-high (port name kept per codebase convention; asserted = 1)
- start  in  1  one-cycle frame request; ignored unless idle
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after the last tap is accepted
- load_go  out  1  one-cycle pulse to the source buffer's go input
- load_ready  in  1  one-cycle pulse from the buffer: load complete
- rom_cena  out  1  active-low read enable to the buffer
- rom_aa  out  AW  read address to the buffer
- tap_valid  out  1  the buffer read data is valid for the consumer
- tap_ready  in  1  consumer accepts the tap this cycle
- tap_first  out  1  with tap_valid: first tap (kr=0, kc=0) of a window
- tap_last  out  1  with tap_valid: last tap (kr=K-1, kc=K-1) of a window
- frame_last  out  1  with tap_valid: last tap of the last window

Behaviour:
- Reset values: busy=0, done=0, load_go=0, rom_cena=1, rom_aa=0, tap_valid=0, tap_first=0, tap_last=0, frame_last=0. State returns to IDLE and all counters clear.
- Reset mid-frame aborts the frame immediately. There is no done pulse, and any in-flight tap is dropped.
- States:
  - IDLE: on start, go to LOAD. load_go=1 for exactly that cycle, and busy rises on the next cycle.
  - LOAD: wait for load_ready, then go to SCAN. load_ready seen in IDLE or SCAN is ignored. start while busy is ignored.
  - SCAN: issue reads. After issuing the final tap, go to DRAIN.
  - DRAIN: wait for the final tap_valid && tap_ready, then go to IDLE. done=1 for 1 cycle and busy=0 on that same cycle.
- Counters (raster order, innermost first):
  - kc: 0..K-1
  - kr: 0..K-1
  - oc: 0..IMG_W-K
  - orow: 0..IMG_H-K
- Address: rom_aa = (orow+kr)*IMG_W + oc + kc, truncated to AW bits. The maximum at defaults is 783, so it fits. Computing it incrementally or with a multiplier are both acceptable, but the value must match exactly.
- Issue rule: in SCAN, issue (rom_cena=0) in a cycle iff (!tap_valid || tap_ready). Counters advance only on an issue.
- Read latency: tap_valid rises the cycle after an issue, aligned with the buffer's read data.
- Stall: while tap_valid && !tap_ready, rom_cena stays 1, so the buffer holds its read data. tap_valid and the markers hold stable.
- tap_valid falls after acceptance unless a new issue happened in the same cycle.
- Throughput: 1 tap/cycle while tap_ready is held high.
- Markers tap_first, tap_last and frame_last are registered alongside each issue, so they stay aligned with the data.
- Totals at defaults: 24*24 = 576 windows, 14400 taps. frame_last accompanies tap #14400 (address 783).
- rom_cena is 1 in IDLE, LOAD and DRAIN. rom_aa may hold its last value when not reading.

Decomposition:
- Shared package:
  - Image/kernel constants: IMG_W, IMG_H, K, and the output size derived as IMG_W-K+1.
  - State enum: IDLE, LOAD, SCAN, DRAIN.
  - Address-width constant.
- One natural sub-module, win_tap_counter:
  - Nested kc/kr/oc/orow counters with an advance enable.
  - Outputs the address, the first/last-tap flags and frame-end.
  - The FSM and handshake stay in src_scan_ctrl.

Test Plan:
- Reset, then start; load_ready 790 cycles later -> load_go pulses once on the start cycle. No rom_cena=0 before load_ready. SCAN is entered the cycle after load_ready.
- tap_ready held 1 -> first 10 addresses are 0,1,2,3,4,28,29,30,31,32. tap_first on address 0, tap_last on address 116. The second window starts at address 1. There are 14400 taps. The last address is 783, carrying frame_last. done pulses once, and busy falls with it.
- tap_ready toggled randomly (30% low) with a reference model of the buffer -> each tap value equals the model data for its expected address. There are no duplicates or drops, and rom_cena=1 during every stalled cycle.
- tap_ready held 0 for 50 cycles after the first tap -> exactly one read was issued, tap_valid stays 1 with data and markers unchanged, and the scan resumes on release.
- start pulsed during SCAN, and load_ready pulsed during SCAN -> both are ignored, and the tap count and addresses are unchanged.
- Reset asserted at tap #5000, then a new start -> all outputs take their reset values the next cycle, with no done pulse. The new frame begins at address 0 after a fresh load_go/load_ready exchange.
